// File: rtl/coffee_machine_top.sv
// Coin-operated coffee controller: debounced buttons, credit/brew FSM, muxed 7-seg.
// Build option BREW_ANIM_EN: rotating-segment brew animation instead of dashes.
module coffee_machine_top #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned DEBOUNCE_MS  = 10,
    parameter int unsigned COIN_VALUE   = 100,
    parameter int unsigned COFFEE_PRICE = 300,
    parameter int unsigned BREW_MS      = 5000,
    parameter int unsigned MAX_CREDIT   = 9900,
    parameter int unsigned SCAN_HZ      = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam longint unsigned DB_CYC =
        64'(DEBOUNCE_MS) * 64'(CLK_HZ) / 64'd1000;
    localparam longint unsigned BR_CYC =
        64'(BREW_MS) * 64'(CLK_HZ) / 64'd1000;
    localparam longint unsigned SC_CYC = 64'(CLK_HZ / SCAN_HZ);

    localparam int DB_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int BR_W = (BR_CYC > 1) ? $clog2(BR_CYC) : 1;
    localparam int SC_W = (SC_CYC > 1) ? $clog2(SC_CYC) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);
    localparam logic [BR_W-1:0] BR_LOAD = BR_W'(BR_CYC - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SC_CYC - 1);

    localparam logic [13:0] PRICE = 14'(COFFEE_PRICE);
    localparam logic [13:0] COIN  = 14'(COIN_VALUE);
    localparam logic [13:0] MAXC  = 14'(MAX_CREDIT);

    typedef enum logic {READY, BREWING} state_t;

    logic [2:0]      s1_q, s2_q, db_q, dbp_q;
    logic [DB_W-1:0] cnt_q [3];
    logic [2:0]      ev;

    state_t          state_q, state_d;
    logic [13:0]     credit_q, credit_d;
    logic [BR_W-1:0] timer_q, timer_d;

    logic [SC_W-1:0] rc_q, rc_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q;
    logic [7:0]      seg_q, seg_d;
    logic [7:0]      brew_seg;
    logic [3:0]      dig0, dig1, dig2, dig3;

    function automatic logic [7:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    enc7 = 8'hC0;
            4'd1:    enc7 = 8'hF9;
            4'd2:    enc7 = 8'hA4;
            4'd3:    enc7 = 8'hB0;
            4'd4:    enc7 = 8'h99;
            4'd5:    enc7 = 8'h92;
            4'd6:    enc7 = 8'h82;
            4'd7:    enc7 = 8'hF8;
            4'd8:    enc7 = 8'h80;
            4'd9:    enc7 = 8'h90;
            default: enc7 = 8'hFF;
        endcase
    endfunction

    // Synchronize, debounce and keep the previous debounced level per button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            db_q  <= '0;
            dbp_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            s1_q  <= btn;
            s2_q  <= s1_q;
            dbp_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                if (s2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    cnt_q[i] <= '0;
                    db_q[i]  <= s2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign ev = db_q & ~dbp_q;

    // Credit / brew state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= READY;
            credit_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
        end
    end

    // Event handling: return > coffee > coin; everything ignored while brewing
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        unique case (state_q)
            READY: begin
                if (ev[1]) begin
                    credit_d = '0;
                end else if (ev[2]) begin
                    if (credit_q >= PRICE) begin
                        credit_d = credit_q - PRICE;
                        timer_d  = BR_LOAD;
                        state_d  = BREWING;
                    end
                end else if (ev[0]) begin
                    if ({1'b0, credit_q} + {1'b0, COIN} <= {1'b0, MAXC})
                        credit_d = credit_q + COIN;
                end
            end
            BREWING: begin
                if (timer_q == '0) state_d = READY;
                else               timer_d = timer_q - BR_W'(1);
            end
        endcase
    end

`ifdef BREW_ANIM_EN
    localparam longint unsigned AN_CYC = 64'(CLK_HZ / 10);
    localparam int AN_W = (AN_CYC > 1) ? $clog2(AN_CYC) : 1;
    localparam logic [AN_W-1:0] AN_LAST = AN_W'(AN_CYC - 1);

    logic [AN_W-1:0] acnt_q;
    logic [2:0]      ph_q;

    // Segment rotation a..f, held at 'a' while READY so a brew starts there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acnt_q <= '0;
            ph_q   <= '0;
        end else if (state_q == READY) begin
            acnt_q <= '0;
            ph_q   <= '0;
        end else if (acnt_q == AN_LAST) begin
            acnt_q <= '0;
            ph_q   <= (ph_q == 3'd5) ? 3'd0 : ph_q + 3'd1;
        end else begin
            acnt_q <= acnt_q + AN_W'(1);
        end
    end

    assign brew_seg = ~(8'h01 << ph_q);
`else
    assign brew_seg = 8'hBF;
`endif

    assign dig0 = 4'(credit_q % 14'd10);
    assign dig1 = 4'((credit_q / 14'd10) % 14'd10);
    assign dig2 = 4'((credit_q / 14'd100) % 14'd10);
    assign dig3 = 4'((credit_q / 14'd1000) % 14'd10);

    // Scan index advance and pattern for the digit about to be enabled
    always_comb begin
        rc_d  = rc_q + SC_W'(1);
        idx_d = idx_q;
        if (rc_q == SC_LAST) begin
            rc_d  = '0;
            idx_d = idx_q + 2'd1;
        end
        seg_d = 8'hFF;
        if (state_q == BREWING) begin
            seg_d = brew_seg;
        end else begin
            unique case (idx_d)
                2'd0: seg_d = enc7(dig0);
                2'd1: if (credit_q >= 14'd10)   seg_d = enc7(dig1);
                2'd2: if (credit_q >= 14'd100)  seg_d = enc7(dig2);
                2'd3: if (credit_q >= 14'd1000) seg_d = enc7(dig3);
            endcase
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rc_q  <= '0;
            idx_q <= '0;
            an_q  <= 4'b1111;
            seg_q <= 8'hFF;
        end else begin
            rc_q  <= rc_d;
            idx_q <= idx_d;
            an_q  <= ~(4'b0001 << idx_d);
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_coffee_machine_top.sv
// Self-checking bench for coffee_machine_top with scaled timing.
// A spec-level model of credit/brew/scan is checked every cycle.
module tb_coffee_machine_top;

    localparam int CLK_HZ      = 10000;
    localparam int DEBOUNCE_MS = 1;
    localparam int BREW_MS     = 100;
    localparam int SCAN_HZ     = 1000;
    localparam int DB   = DEBOUNCE_MS * CLK_HZ / 1000;
    localparam int B    = BREW_MS * CLK_HZ / 1000;
    localparam int P    = CLK_HZ / SCAN_HZ;
    localparam int ANIM = CLK_HZ / 10;
    localparam int LAT  = 2 + DB + 1;

    localparam logic [7:0] SEG7 [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef BREW_ANIM_EN
    localparam logic [7:0] BREW_LIT = 8'hFE;
`else
    localparam logic [7:0] BREW_LIT = 8'hBF;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] btn;
    logic [3:0] an;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;
    int edge_n;
    int m_credit;
    bit brew_v;
    int brew_e;
    bit chk_on;

    always #5 clk = ~clk;

    coffee_machine_top #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .COIN_VALUE  (100),
        .COFFEE_PRICE(300),
        .BREW_MS     (BREW_MS),
        .MAX_CREDIT  (9900),
        .SCAN_HZ     (SCAN_HZ)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .btn  (btn),
        .an   (an),
        .seg  (seg)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] disp(int idx, int cr);
        int pw;
        pw = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        if (idx > 0 && cr < pw) return 8'hFF;
        return SEG7[(cr / pw) % 10];
    endfunction

    function automatic logic [7:0] brew_pat(int n);
`ifdef BREW_ANIM_EN
        logic [7:0] one;
        int ph;
        one = 8'h01;
        ph  = ((n - 1 - brew_e) / ANIM) % 6;
        return ~(one << ph);
`else
        return 8'hBF + 8'(n - n);
`endif
    endfunction

    task automatic monitor();
        int idx;
        bit br, blk;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n || edge_n == 0) begin
                chk("rst_an", {4'h0, an}, 8'h0F);
                chk("rst_seg", seg, 8'hFF);
            end else begin
                idx = (edge_n / P) % 4;
                chk("an_scan", {4'h0, an}, {4'h0, ~(4'b0001 << idx)});
                br  = brew_v && edge_n >= brew_e + 1 && edge_n <= brew_e + B;
                blk = brew_v && edge_n >= brew_e + B - 1
                             && edge_n <= brew_e + B + 2;
                if (chk_on && !blk) begin
                    e = br ? brew_pat(edge_n) : disp(idx, m_credit);
                    chk("seg", seg, e);
                end
            end
        end
    endtask

    task automatic apply(int b, int a);
        if (brew_v && a <= brew_e + B) return;
        case (b)
            1: m_credit = 0;
            2: if (m_credit >= 300) begin
                   m_credit -= 300;
                   brew_v = 1'b1;
                   brew_e = a;
               end
            default: if (m_credit + 100 <= 9900) m_credit += 100;
        endcase
    endtask

    task automatic press(int b, int hold, int gap);
        int t0;
        @(posedge clk); #1;
        t0 = edge_n;
        btn[b] = 1'b1;
        for (int k = 1; k <= hold + gap; k++) begin
            @(posedge clk); #1;
            if (k == hold) btn[b] = 1'b0;
            if (k == LAT - 1) begin
                chk_on = 1'b0;
                if (hold >= DB) apply(b, t0 + LAT);
            end
            if (k == LAT + 2) chk_on = 1'b1;
        end
    endtask

    task automatic wait_edge(int target);
        while (edge_n < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic read_digits(string nm, logic [7:0] e3, logic [7:0] e2,
                               logic [7:0] e1, logic [7:0] e0);
        logic [7:0] got [4];
        bit seen [4];
        logic [3:0] sel;
        for (int i = 0; i < 4; i++) begin
            seen[i] = 1'b0;
            got[i]  = 8'h00;
        end
        for (int c = 0; c < 6 * P; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                sel = ~(4'b0001 << i);
                if (an == sel) begin
                    got[i]  = seg;
                    seen[i] = 1'b1;
                end
            end
            if (seen[0] && seen[1] && seen[2] && seen[3]) break;
        end
        if (!(seen[0] && seen[1] && seen[2] && seen[3])) begin
            checks++;
            errors++;
            $display("FAIL %s: scan timeout, got an %b want all digits", nm, an);
        end else begin
            chk({nm, "_d3"}, got[3], e3);
            chk({nm, "_d2"}, got[2], e2);
            chk({nm, "_d1"}, got[1], e1);
            chk({nm, "_d0"}, got[0], e0);
        end
    endtask

    initial begin
        btn      = 3'b000;
        chk_on   = 1'b1;
        m_credit = 0;
        brew_v   = 1'b0;
        brew_e   = 0;
        #2 rst_n = 1'b0;
        fork
            monitor();
        join_none
        #21;
        chk("reset_an", {4'h0, an}, 8'h0F);
        chk("reset_seg", seg, 8'hFF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10 * P) @(posedge clk);

        repeat (3) press(0, 15 * P, 15 * P);
        read_digits("t1_300", 8'hFF, 8'hB0, 8'hC0, 8'hC0);

        press(2, 20, 20);
        read_digits("t2_brew", BREW_LIT, BREW_LIT, BREW_LIT, BREW_LIT);
        press(0, 20, 20);
        press(1, 20, 20);
        wait_edge(brew_e + B - 5);
        @(negedge clk);
        chk("t3_no_early_exit", seg, BREW_LIT);
        wait_edge(brew_e + B * 51 / 50);
        read_digits("t2_done", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

        repeat (4) press(0, 12, 20);
        press(2, 12, 20);
        press(1, 12, 20);
        press(0, 12, 20);
        wait_edge(brew_e + B + 20);
        read_digits("t3_kept", 8'hFF, 8'hF9, 8'hC0, 8'hC0);

        press(0, 12, 20);
        press(2, 12, 20);
        read_digits("t4_200", 8'hFF, 8'hA4, 8'hC0, 8'hC0);
        press(1, 12, 20);
        read_digits("t4_ret", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        press(1, 12, 20);

        press(0, 5, 30);
        press(0, DB - 1, 30);
        read_digits("t5_glitch", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        press(0, DB, 30);
        press(0, 100 * P, 30);
        read_digits("t5_hold", 8'hFF, 8'hA4, 8'hC0, 8'hC0);

        for (int i = 0; i < 97; i++) press(0, 12, 20);
        read_digits("t6_max", 8'h90, 8'h90, 8'hC0, 8'hC0);
        press(0, 12, 20);
        read_digits("t6_sat", 8'h90, 8'h90, 8'hC0, 8'hC0);

        press(2, 12, 20);
        wait_edge(brew_e + 200);
        @(posedge clk);
        #2 rst_n = 1'b0;
        brew_v   = 1'b0;
        m_credit = 0;
        #1;
        chk("t6_rst_an", {4'h0, an}, 8'h0F);
        chk("t6_rst_seg", seg, 8'hFF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5 * P) @(posedge clk);
        read_digits("t6_after", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
